// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding word fetch, in-order {pc, inst} queue.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  fsm_state
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   q_inst [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];

    logic accept, push, pop, drop_ev;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge (imem_req/imem_ready, inst_valid/id_ready); valid
    // never depends on ready. imem_rvalid is a one-way strobe, one per accept.
    assign imem_req   = rst & (state == IDLE) & ~br_taken & (count < CW'(QUEUE_DEPTH));
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req & imem_ready;
    assign push       = (state == WAIT) & imem_rvalid & ~br_taken;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & id_ready & ~br_taken;
    assign drop_ev    = imem_rvalid & (((state == WAIT) & br_taken) | (state == DROP));
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign fsm_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: begin
                if (br_taken) state_nxt = imem_rvalid ? IDLE : DROP;
                else if (imem_rvalid) state_nxt = IDLE;
            end
            DROP: if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (br_taken) begin
                fetch_pc <= {br_target[31:2], 2'b00};
            end else if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // A redirect clears the queue outright; same-cycle push and pop are void.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (br_taken) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (push)    perf_fetched <= perf_fetched + 32'd1;
            if (drop_ev) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_ev;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, then randomized traffic
// against a transaction-level queue model with a behavioural instruction memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  fsm_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .fsm_state(fsm_state)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] tgt;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rdata,
                                input logic br, input logic [31:0] tgt, input logic idr,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.ready = ready; v.rv = rv; v.rdata = rdata; v.br = br; v.tgt = tgt; v.idr = idr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t tbl [18];

    // ---------------- memory + reference model ----------------
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr    = '0;

    logic [63:0] exp_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_out;
    logic        m_disc;
    int          m_fetched;
    int          m_dropped;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h0280_0400;
    endfunction

    // One cycle: drive at negedge, check at +1, advance both models at posedge.
    task automatic rand_cycle(input int br_pct, input int idr_mode, input bit force_rv);
        logic ready, rv, br, idr, exp_req, acc_dut;
        logic [31:0] rdata, tgt, dut_addr;
        int sz;
        ready = ($urandom_range(0, 99) < 70) || force_rv;
        rv    = mem_pending && (force_rv || ($urandom_range(0, 99) < 60));
        rdata = rv ? data_of(mem_addr) : $urandom;
        br    = ($urandom_range(0, 99) < br_pct);
        case ($urandom_range(0, 3))
            0:       tgt = 32'hffff_fff0 | 32'($urandom_range(0, 15));
            default: tgt = RESET_PC | ($urandom & 32'h0000_0fff);
        endcase
        idr = (idr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(idr_mode);
        imem_ready = ready; imem_rvalid = rv; imem_rdata = rdata;
        br_taken = br; br_target = tgt; id_ready = idr;
        #1;
        sz = exp_q.size();
        exp_req = !m_out && !br && (sz < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(sz > 0));
        if (sz > 0) begin
            chk("inst_pc", inst_pc, exp_q[0][63:32]);
            chk("inst", inst, exp_q[0][31:0]);
        end
        acc_dut  = imem_req && imem_ready;
        dut_addr = imem_addr;
        @(posedge clk);
        if (rv) mem_pending = 1'b0;
        if (acc_dut) begin
            mem_pending = 1'b1;
            mem_addr    = dut_addr;
        end
        if (br) begin
            m_pc = tgt & ~32'd3;
            exp_q.delete();
            if (m_out) begin
                if (rv) begin
                    m_out = 1'b0; m_disc = 1'b0; m_dropped++;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            if (m_out && rv) begin
                if (m_disc) m_dropped++;
                else begin
                    exp_q.push_back({m_req_pc, rdata});
                    m_fetched++;
                end
                m_out = 1'b0; m_disc = 1'b0;
            end
            if (sz > 0 && idr) void'(exp_q.pop_front());
            if (exp_req && ready) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; id_ready = 1'b1;

        tbl[0]  = mk(1,0,32'h0,       0,32'h0,       1, 1,32'h1c000000, 0,32'h0,0);
        tbl[1]  = mk(1,1,32'h02800400,0,32'h0,       1, 0,32'h1c000004, 0,32'h0,0);
        tbl[2]  = mk(1,0,32'h0,       0,32'h0,       1, 1,32'h1c000004, 1,32'h02800400,32'h1c000000);
        tbl[3]  = mk(1,1,32'h02800401,0,32'h0,       1, 0,32'h1c000008, 0,32'h0,0);
        tbl[4]  = mk(1,0,32'h0,       0,32'h0,       1, 1,32'h1c000008, 1,32'h02800401,32'h1c000004);
        tbl[5]  = mk(1,0,32'h0,       1,32'h1c000103,1, 0,32'h1c00000c, 0,32'h0,0);
        tbl[6]  = mk(1,1,32'hdeadbeef,0,32'h0,       1, 0,32'h1c000100, 0,32'h0,0);
        tbl[7]  = mk(1,0,32'h0,       0,32'h0,       1, 1,32'h1c000100, 0,32'h0,0);
        tbl[8]  = mk(1,1,32'h02800500,0,32'h0,       0, 0,32'h1c000104, 0,32'h0,0);
        tbl[9]  = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h1c000104, 1,32'h02800500,32'h1c000100);
        tbl[10] = mk(1,1,32'h02800501,0,32'h0,       0, 0,32'h1c000108, 1,32'h02800500,32'h1c000100);
        tbl[11] = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h1c000108, 1,32'h02800500,32'h1c000100);
        tbl[12] = mk(1,1,32'h02800502,1,32'h1c000200,1, 0,32'h1c00010c, 1,32'h02800500,32'h1c000100);
        tbl[13] = mk(0,0,32'h0,       0,32'h0,       1, 1,32'h1c000200, 0,32'h0,0);
        tbl[14] = mk(1,0,32'h0,       0,32'h0,       1, 1,32'h1c000200, 0,32'h0,0);
        tbl[15] = mk(1,1,32'h02800600,0,32'h0,       1, 0,32'h1c000204, 0,32'h0,0);
        tbl[16] = mk(0,0,32'h0,       0,32'h0,       1, 1,32'h1c000204, 1,32'h02800600,32'h1c000200);
        tbl[17] = mk(0,0,32'h0,       0,32'h0,       1, 1,32'h1c000204, 0,32'h0,0);

        // reset state, with imem_ready high so imem_req must be held low by reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            imem_ready = tbl[i].ready; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
            br_taken = tbl[i].br; br_target = tbl[i].tgt; id_ready = tbl[i].idr;
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
                chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
            end
            @(negedge clk);
        end
`ifdef IF_PERF_CNT_EN
        chk("tbl_perf_fetched", perf_fetched, 32'd5);
        chk("tbl_perf_dropped", perf_dropped, 32'd2);
`endif

        // hand over to the model from the known post-table state
        m_pc = 32'h1c00_0204; m_req_pc = '0; m_out = 1'b0; m_disc = 1'b0;
        m_fetched = 5; m_dropped = 2;
        exp_q.delete();

        // fill: decode stalled, memory answers at once -> queue fills, requests stop
        for (int i = 0; i < 14; i++) rand_cycle(0, 0, 1'b1);
        imem_ready = 1'b1; br_taken = 1'b0; id_ready = 1'b0; imem_rvalid = 1'b0;
        #1;
        chk("full_no_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(inst_valid), 32'd1);
        @(negedge clk);
        // drain in order, fetching resumes
        for (int i = 0; i < 14; i++) rand_cycle(0, 1, 1'b1);
        // randomized mix of latency, stalls and redirects
        for (int i = 0; i < 2000; i++) rand_cycle(6, 2, 1'b0);
        // let any outstanding response land without further redirects
        for (int i = 0; i < 8; i++) rand_cycle(0, 1, 1'b1);

`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_dropped", perf_dropped, 32'(m_dropped));
`endif

        // asynchronous reset mid-run, applied away from any clock edge
        imem_ready = 1'b1; br_taken = 1'b0; id_ready = 1'b0; imem_rvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'd0);
        chk("arst_inst_valid", 32'(inst_valid), 32'd0);
        chk("arst_imem_addr", imem_addr, RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
